// File: rtl/serial_add_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_pkg
// Description : Shared definitions for the bit-serial adder controller:
//               FSM state encoding, default operand width and the bit
//               counter width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Bit counter only has to reach WIDTH-1; a one-bit floor keeps the
  // vector legal for degenerate widths.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_add_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_ctrl_if
// Description : Request/result bundle between an operand source/consumer
//               (master) and the bit-serial adder controller (slave).
//   start  : request, accepted in IDLE or DONE
//   x, y   : WIDTH-bit operands, c_in : carry-in
//   busy   : operation in progress, done : one-cycle result-valid pulse
//   sum    : registered result, c_out : registered carry-out
//   ovf    : signed overflow, present only with SERIAL_ADD_OVF_EN defined
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_add_ctrl_if #(
  parameter int WIDTH = serial_add_pkg::DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf;

  modport master (output start, x, y, c_in,
                  input  busy, done, sum, c_out, ovf);
  modport slave  (input  start, x, y, c_in,
                  output busy, done, sum, c_out, ovf);
`else
  modport master (output start, x, y, c_in,
                  input  busy, done, sum, c_out);
  modport slave  (input  start, x, y, c_in,
                  output busy, done, sum, c_out);
`endif

endinterface
`default_nettype wire

// File: rtl/full_adder_cell.sv
`default_nettype none
// ============================================================================
// Module      : full_adder_cell
// Description : Combinational 1-bit full adder built from two half adders;
//               the single arithmetic resource time-shared by the
//               serial adder controller.
//   a, b, c_in : input bits and carry-in
//   sum        : a ^ b ^ c_in
//   c_out      : carry-out
// Revision    : 1.0 - initial release
// ============================================================================
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);

  logic ha0_sum;
  logic ha0_carry;
  logic ha1_carry;

  half_adder u_ha0 (
    .a     (a),
    .b     (b),
    .sum   (ha0_sum),
    .carry (ha0_carry)
  );

  half_adder u_ha1 (
    .a     (ha0_sum),
    .b     (c_in),
    .sum   (sum),
    .carry (ha1_carry)
  );

  // The two half-adder carries can never both be set, so OR is exact.
  assign c_out = ha0_carry | ha1_carry;

endmodule
`default_nettype wire

// File: rtl/half_adder.sv
`default_nettype none
// ============================================================================
// Module      : half_adder
// Description : Combinational 1-bit half adder.
//   a, b  : input bits
//   sum   : a XOR b
//   carry : a AND b
// Revision    : 1.0 - initial release
// ============================================================================
module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule
`default_nettype wire

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_ctrl
// Description : Bit-serial adder controller. Sequences one full_adder_cell
//               over WIDTH cycles to compute {c_out,sum} = x + y + c_in.
//   clk    : single clock, rising edge
//   rst_n  : synchronous active-low reset
//   bus    : serial_add_ctrl_if slave (start/x/y/c_in in,
//            busy/done/sum/c_out[/ovf] out)
// Build option: SERIAL_ADD_OVF_EN adds the registered signed-overflow
//               output ovf.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  serial_add_ctrl_if.slave bus
);

  localparam int              CNT_W      = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  // Only WIDTH-1 result bits need storing: the last bit goes straight
  // from the cell into sum on the final edge.
  logic [WIDTH-2:0] acc_q, acc_d, acc_shift;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             c_out_q, c_out_d;
  logic             cell_sum;
  logic             cell_c_out;
  logic             accept;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  full_adder_cell u_cell (
    .a     (x_q[0]),
    .b     (y_q[0]),
    .c_in  (carry_q),
    .sum   (cell_sum),
    .c_out (cell_c_out)
  );

  // LSB-first fill: each new sum bit enters at the MSB.
  generate
    if (WIDTH > 2) begin : g_acc_wide
      assign acc_shift = {cell_sum, acc_q[WIDTH-2:1]};
    end else begin : g_acc_narrow
      assign acc_shift = cell_sum;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif
    accept  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        accept = bus.start;
      end
      ST_RUN: begin
        x_d     = x_q >> 1;
        y_d     = y_q >> 1;
        acc_d   = acc_shift;
        carry_d = cell_c_out;
        if (cnt_q == C_CNT_LAST) begin
          // Counter holds at WIDTH-1; it is reloaded on the next accept.
          sum_d   = {cell_sum, acc_q};
          c_out_d = cell_c_out;
`ifdef SERIAL_ADD_OVF_EN
          // carry_q is the carry into the MSB on this final step.
          ovf_d   = carry_q ^ cell_c_out;
`endif
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        accept = bus.start;
        if (!bus.start) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (accept) begin
      x_d     = bus.x;
      y_d     = bus.y;
      carry_d = bus.c_in;
      cnt_d   = '0;
      state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.busy  = (state_q == ST_RUN);
  assign bus.done  = (state_q == ST_DONE);
  assign bus.sum   = sum_q;
  assign bus.c_out = c_out_q;
`ifdef SERIAL_ADD_OVF_EN
  assign bus.ovf   = ovf_q;
`endif

endmodule
`default_nettype wire

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

- Bit-serial adder controller: sequences one shared 1-bit adder cell over WIDTH cycles to add two WIDTH-bit operands plus a carry-in.
- Replaces a ripple of WIDTH adder cells with one cell, a bit counter and shift registers.
- Sits between an operand source issuing `start` and a consumer that waits for `done`.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range 2–32.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE or DONE.
- `x`  in  WIDTH  operand A; sampled with an accepted `start`.
- `y`  in  WIDTH  operand B; sampled with an accepted `start`.
- `c_in`  in  1  carry-in; sampled with an accepted `start`.
- `busy`  out  1  high while the operation is in progress.
- `done`  out  1  one-cycle pulse; result valid.
- `sum`  out  WIDTH  registered result, held until the next completion.
- `c_out`  out  1  registered carry-out, held with `sum`.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: `start`=1 → latch x/y into shift registers, carry reg ← `c_in`, cnt ← 0, go to RUN.
- RUN, each edge:
  - Bit cell adds the operand LSBs and the carry reg.
  - Sum bit shifts into the accumulator MSB (LSB-first fill).
  - Operand registers shift right; carry reg ← cell carry; cnt ← cnt+1.
- RUN, edge with cnt==WIDTH-1: after the shift above, `sum` ← accumulator, `c_out` ← cell carry, go to DONE.
- DONE: `done`=1 for one cycle.
  - `start`=1 → accept a new operation exactly as in IDLE (back-to-back).
  - Otherwise → IDLE.
- `start` in RUN is ignored. It is not queued. The requester must hold or reissue it.
- Arithmetic: {c_out,sum} = x + y + c_in, unsigned, exact, with no truncation.
- cnt width is $clog2(WIDTH). cnt never wraps past WIDTH-1.
- Reset mid-operation: aborts the operation and discards partial state. No `done` is produced.

## Timing
- Reset values: `busy`=0, `done`=0, `sum`=0, `c_out`=0, FSM=IDLE, cnt=0.
- Edge E0 accepts `start`. `busy`=1 from after E0 through the edge E_WIDTH.
- `sum`/`c_out` update only on edge E_WIDTH.
- After E_WIDTH: `done`=1 and `busy`=0 for one cycle.
- Latency: WIDTH+1 cycles from `start` sample to the `done` cycle.
- Throughput: one result per WIDTH+1 cycles with back-to-back `start`.
- `sum`/`c_out` stay stable in all other cycles, including during the next RUN.
- `busy` and `done` are never high together.

## Configuration
- Macro: `SERIAL_ADD_OVF_EN`.
- Defined:
  - Adds output `ovf` (out, 1).
  - `ovf` is the signed (two's-complement) overflow: carry into the MSB XOR carry out of the MSB.
  - Registered on edge E_WIDTH with `sum`. Reset value 0.
- Undefined:
  - `ovf` port is absent.
  - No extra registers.
  - All other behaviour is identical.

## Structure
- Shared package `serial_add_pkg`:
  - FSM state enum (IDLE/RUN/DONE).
  - Default WIDTH constant.
  - Counter-width function.
- One sub-module, `full_adder_cell` (a, b, c_in → sum, c_out):
  - Built from two half-adder instances plus an OR for the carries.
  - Purely combinational.
  - This is the shared 1-bit resource sequenced by the controller.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with `start`=1 → all outputs 0, no `done`; release → IDLE.
- WIDTH=8, x=0x0F, y=0x01, c_in=0 → `done` at cycle 9 after start, `sum`=0x10, `c_out`=0; `busy` high for exactly 8 cycles.
- Overflow: x=0xFF, y=0x01, c_in=1 → `sum`=0x01, `c_out`=1.
  - With `SERIAL_ADD_OVF_EN`: x=0x7F, y=0x01 → `sum`=0x80, `ovf`=1.
  - With `SERIAL_ADD_OVF_EN`: x=0xFF, y=0x01 → `ovf`=0.
- Back-to-back: `start` high in the DONE cycle with x=0x03, y=0x04 → second `done` exactly 9 cycles later, `sum`=0x07. The first result stays held until then.
- Ignored start: pulse `start` with x=0xAA during RUN of 0x01+0x01 → result 0x02; no second operation.
- Abort: assert `rst_n`=0 at cycle 4 of RUN → `busy`=0 next cycle, `sum`=0, no `done` pulse.
- Exhaustive (WIDTH=4): all 512 x/y/c_in combinations → {c_out,sum} equals the reference sum every time.
